// File: rtl/hex_entry_if.sv
// Switch/button inputs and entered-value outputs of the hex entry front end.
interface hex_entry_if;
  logic [15:0] sw;
  logic        btn_del;
  logic        btn_clr;
  logic [31:0] data;
  logic        digit_valid;
  logic [3:0]  digit;
  logic [3:0]  cnt;

  modport master (output sw, btn_del, btn_clr, input data, digit_valid, digit, cnt);
  modport slave  (input sw, btn_del, btn_clr, output data, digit_valid, digit, cnt);
endinterface

// File: rtl/hex_entry.sv
// Hex digit entry: sync + debounce 16 switches and two buttons, shift digits into a 32-bit value.
module hex_entry #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  hex_entry_if.slave  bus
);
  localparam int W  = 18;
  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef logic [CW-1:0] ctr_t;
  localparam ctr_t DB_MAX  = ctr_t'(DB_CYCLES);
  localparam ctr_t DB_LAST = ctr_t'(DB_CYCLES - 1);

  logic [W-1:0] raw, sync1, sync2, prev, db, chg;
  ctr_t         stable;
  logic         commit;

  assign raw    = {bus.btn_clr, bus.btn_del, bus.sw};
  assign commit = (stable == DB_LAST) && (sync2 != db);

  // Everything loads the live inputs in reset so the current level becomes the baseline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= raw;
      sync2  <= raw;
      prev   <= raw;
      db     <= raw;
      stable <= '0;
      chg    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev)
        stable <= '0;
      else if (stable != DB_MAX)
        stable <= stable + 1'b1;
      chg <= commit ? (db ^ sync2) : '0;
      if (commit)
        db <= sync2;
    end
  end

  // chg is one cycle old here, so db already holds the new level.
  logic [W-1:0] rise;
  logic         ev_clr, ev_del, ev_dig;
  logic [3:0]   top;

  assign rise   = chg & db;
  assign ev_clr = rise[17];
  assign ev_del = rise[16];
  assign ev_dig = |chg[15:0];

  always_comb begin
    top = '0;
    for (int i = 0; i < 16; i++)
      if (chg[i]) top = 4'(i);
  end

  logic [31:0] data;
  logic [3:0]  cnt, digit;
  logic        digit_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      data        <= '0;
      cnt         <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      if (ev_clr) begin
        data <= '0;
        cnt  <= '0;
      end else if (ev_del) begin
        data <= data >> 4;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end else if (ev_dig) begin
        data        <= {data[27:0], top};
        if (cnt != 4'd8) cnt <= cnt + 4'd1;
        digit       <= top;
        digit_valid <= 1'b1;
      end
    end
  end

  assign bus.data        = data;
  assign bus.cnt         = cnt;
  assign bus.digit       = digit;
  assign bus.digit_valid = digit_valid;
endmodule

// File: tb/tb_hex_entry.sv
// Randomized bench for hex_entry against a digit-queue reference model.
module tb_hex_entry;
  logic clk, rst;
  hex_entry_if bus();

  hex_entry #(.DB_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int pulses = 0, p0;

  always @(negedge clk) if (bus.digit_valid === 1'b1) pulses++;

  // Reference: the entered digits as a queue, newest at the back, at most 8 kept.
  logic [3:0]  q[$];
  logic [3:0]  last_digit;
  logic [17:0] cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata();
    logic [31:0] d = '0;
    foreach (q[i]) d = {d[27:0], q[i]};
    return d;
  endfunction

  function automatic int model(input logic [17:0] o, input logic [17:0] n);
    logic [17:0] c = o ^ n;
    int hi = -1;
    if (c[17] && n[17]) begin
      q.delete();
      return 0;
    end
    if (c[16] && n[16]) begin
      if (q.size() > 0) void'(q.pop_back());
      return 0;
    end
    for (int i = 0; i < 16; i++) if (c[i]) hi = i;
    if (hi < 0) return 0;
    q.push_back(4'(hi));
    if (q.size() > 8) void'(q.pop_front());
    last_digit = 4'(hi);
    return 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive(input logic [17:0] v);
    @(negedge clk);
    {bus.btn_clr, bus.btn_del, bus.sw} = v;
  endtask

  task automatic verify(input string tag, input int ep);
    chk({tag, ".pulses"}, 32'(pulses - p0), 32'(ep));
    chk({tag, ".data"},   bus.data, mdata());
    chk({tag, ".cnt"},    32'(bus.cnt), 32'(q.size()));
    chk({tag, ".digit"},  32'(bus.digit), 32'(last_digit));
  endtask

  task automatic op(input string tag, input logic [17:0] n);
    int ep;
    p0 = pulses;
    ep = model(cur, n);
    drive(n);
    cur = n;
    tick(12);
    verify(tag, ep);
  endtask

  task automatic enter(input int d);
    logic [17:0] n = cur;
    n[d] = ~n[d];
    op("enter", n);
  endtask

  task automatic clear_all();
    logic [17:0] n = cur;
    if (n[17]) begin n[17] = 1'b0; op("clr_rel0", n); end
    n[17] = 1'b1; op("clr_press", n);
    n[17] = 1'b0; op("clr_rel", n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk) rst = 1'b0;
    q.delete();
    last_digit = '0;
  endtask

  initial begin
    logic [17:0] n;
    int ep, b, len;
    bus.sw = 16'h0005; bus.btn_del = 1'b0; bus.btn_clr = 1'b0;
    cur = 18'h00005;
    do_reset();
    p0 = pulses;
    tick(20);
    verify("reset_baseline", 0);

    // exact-cycle latency of a single toggle
    p0 = pulses;
    n = cur; n[10] = ~n[10];
    ep = model(cur, n);
    drive(n); cur = n;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("latency.e%0d", k), 32'(bus.digit_valid), (k == 7) ? 32'd1 : 32'd0);
    end
    verify("single", ep);
    chk("single.data_abs", bus.data, 32'h0000000A);

    clear_all();
    for (int d = 1; d <= 9; d++) enter(d);
    chk("nine.data_abs", bus.data, 32'h23456789);
    chk("nine.cnt_abs", 32'(bus.cnt), 32'd8);

    // bounce that settles on the new level
    p0 = pulses;
    n = cur; n[3] = ~n[3];
    drive(n); tick(2); drive(cur); tick(2); drive(n);
    ep = model(cur, n); cur = n;
    tick(12);
    verify("bounce", ep);
    chk("bounce.digit_abs", 32'(bus.digit), 32'd3);

    // held delete gives a single event, then delete past empty
    clear_all();
    enter(3); enter(7);
    n = cur; n[16] = 1'b1;
    p0 = pulses; void'(model(cur, n)); drive(n); cur = n;
    tick(50);
    verify("del_hold", 0);
    chk("del_hold.data_abs", bus.data, 32'h3);
    n[16] = 1'b0; op("del_rel", n);
    n[16] = 1'b1; op("del2", n);
    n[16] = 1'b0; op("del2_rel", n);
    n[16] = 1'b1; op("del3", n);
    n[16] = 1'b0; op("del3_rel", n);
    chk("del_empty.data_abs", bus.data, 32'h0);
    chk("del_empty.cnt_abs", 32'(bus.cnt), 32'd0);

    // clear wins over a digit in the same commit
    enter(1); enter(2); enter(3); enter(4);
    chk("prio.pre", bus.data, 32'h1234);
    n = cur; n[2] = ~n[2]; n[17] = 1'b1;
    op("prio", n);
    chk("prio.data_abs", bus.data, 32'h0);
    n[17] = 1'b0; op("prio_rel", n);

    // reset while a change is still being debounced
    n = cur; n[1] = ~n[1];
    drive(n); cur = n;
    tick(2);
    do_reset();
    p0 = pulses;
    tick(20);
    verify("mid_reset", 0);

    for (int it = 0; it < 80; it++) begin
      int kind = $urandom_range(0, 9);
      n = cur;
      b = $urandom_range(0, 17);
      case (kind)
        0, 1, 2, 3: begin n[$urandom_range(0, 15)] ^= 1'b1; op("rnd_sw", n); end
        4: begin n[$urandom_range(0, 15)] ^= 1'b1; n[$urandom_range(0, 15)] ^= 1'b1; op("rnd_sw2", n); end
        5: begin n[16] = ~n[16]; op("rnd_del", n); end
        6: begin n[17] = ~n[17]; op("rnd_clr", n); end
        7: begin n = 18'($urandom); op("rnd_vec", n); end
        8: begin
          len = $urandom_range(1, 3);
          p0 = pulses;
          n[b] = ~n[b];
          drive(n); tick(len); drive(cur);
          tick(12);
          verify("rnd_glitch", 0);
        end
        default: begin
          p0 = pulses;
          n[b] = ~n[b];
          drive(n); tick(2); drive(cur); tick(2); drive(n);
          ep = model(cur, n); cur = n;
          tick(12);
          verify("rnd_bounce", ep);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
